// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-address arbiter: FSM state encoding and
// default sizing used by mem_addr_arbiter and its round-robin picker.
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_NUM_SRC = 4;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational winner selection among NUM_SRC requesters.
//   RR_MODE = 0 : fixed priority, lowest index wins.
//   RR_MODE = 1 : round-robin, search starts at rr_ptr and wraps.
// Requesters with their mask bit set are excluded from the search.
// Ports:
//   req     in   NUM_SRC  raw request vector
//   mask    in   NUM_SRC  requesters to ignore this cycle
//   rr_ptr  in   IDX_W    round-robin search start index
//   winner  out  IDX_W    index of the selected requester
//   valid   out  1        at least one unmasked request present
// -----------------------------------------------------------------------------
module rr_picker
    import mem_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    parameter  int RR_MODE = 0,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [NUM_SRC-1:0] eff;
    logic [IDX_W-1:0]   fp_idx;
    logic [IDX_W-1:0]   rr_idx;

    assign eff = req & ~mask;

    always_comb begin : pick
        int idx;
        idx    = 0;
        fp_idx = '0;
        rr_idx = '0;
        // Descending scans overwrite, so the last hit is the lowest index
        // (fixed priority) or the smallest distance from rr_ptr (round-robin).
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) begin
                fp_idx = IDX_W'(i);
            end
        end
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (eff[idx]) begin
                rr_idx = IDX_W'(idx);
            end
        end
        winner = (RR_MODE != 0) ? rr_idx : fp_idx;
        valid  = |eff;
    end

endmodule

// File: rtl/mem_addr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_addr_arbiter
// Arbitrates NUM_SRC address requesters for the single memory port. The winner's
// address and write flag are latched and held for WAIT_CYCLES cycles of mem_en,
// then the winner receives a one-cycle done pulse. Back-to-back accesses start
// directly from the DONE cycle, giving one access per WAIT_CYCLES+1 cycles.
// Ports:
//   clk       in   1               rising-edge clock
//   reset_n   in   1               asynchronous active-low reset
//   req       in   NUM_SRC         per-source level request
//   src_addr  in   NUM_SRC*ADDR_W  packed addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_wr    in   NUM_SRC         per-source write flag
//   flush     in   1               abort access / suppress arbitration
//   gnt       out  NUM_SRC         one-hot grant, held through ACCESS and DONE
//   mem_en    out  1               memory access strobe
//   mem_wr    out  1               latched write flag
//   mem_addr  out  ADDR_W          latched address
//   done      out  NUM_SRC         one-cycle completion pulse
//   busy      out  1               high in ACCESS or DONE
// -----------------------------------------------------------------------------
module mem_addr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_wr,
    input  logic                      flush,
    output logic [NUM_SRC-1:0]        gnt,
    output logic                      mem_en,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [NUM_SRC-1:0]        done,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]  gnt_d, done_d;
    logic                mem_en_d, mem_wr_d, busy_d;
    logic [ADDR_W-1:0]   mem_addr_d;

    logic [NUM_SRC-1:0]  pick_mask;
    logic [IDX_W-1:0]    win;
    logic                win_vld;
    logic                take;
    logic [ADDR_W-1:0]   addr_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_addr
        assign addr_arr[g] = src_addr[g*ADDR_W +: ADDR_W];
    end

    // The source completing in DONE must not win again in the same cycle.
    assign pick_mask = (state_q == ST_DONE) ? gnt : '0;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .RR_MODE (RR_MODE)
    ) u_picker (
        .req    (req),
        .mask   (pick_mask),
        .rr_ptr (rr_ptr_q),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt;
        done_d     = '0;
        mem_en_d   = mem_en;
        mem_wr_d   = mem_wr;
        mem_addr_d = mem_addr;
        busy_d     = busy;
        take       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = win_vld && !flush;
            end
            ST_ACCESS: begin
                if (flush) begin
                    state_d  = ST_IDLE;
                    mem_en_d = 1'b0;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    done_d   = gnt;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (win_vld && !flush) begin
                    take = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    mem_en_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (take) begin
            state_d    = ST_ACCESS;
            cnt_d      = CNT_INIT;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            mem_addr_d = addr_arr[win];
            mem_wr_d   = src_wr[win];
            mem_en_d   = 1'b1;
            busy_d     = 1'b1;
            rr_ptr_d   = (win == LAST_IDX) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            gnt      <= '0;
            done     <= '0;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gnt      <= gnt_d;
            done     <= done_d;
            mem_en   <= mem_en_d;
            mem_wr   <= mem_wr_d;
            mem_addr <= mem_addr_d;
            busy     <= busy_d;
        end
    end

endmodule
